// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one SD block-read controller between NUM_REQ voices.
// Each grant issues one block read and steers the returned bytes to the owning voice.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// IDLE      | no owner; arbitrate when any req is set and sd_rdy is high
// ISSUE     | one-cycle sd_start; clear byte count, load the start timeout
// WAIT_BUSY | wait for sd_rdy to drop; timeout ends the grant with error
// XFER      | forward bytes to the owner until sd_rdy returns high
// FINISH    | one-cycle done/err pulse to the owner; advance rr_ptr
module sd_block_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BLOCK_BYTES   = 512,
  parameter int START_TIMEOUT = 64
) (
  input  logic                   clk96m,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             rd_data,
  output logic [NUM_REQ-1:0]     rd_valid,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [31:0]            sd_address,
  output logic                   sd_start,
  input  logic                   sd_rdy,
  input  logic [7:0]             sd_data,
  input  logic                   sd_data_valid,
  output logic                   busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BLOCK_BYTES + 2);
  localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BLOCK_BYTES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(START_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_XFER      = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  logic [2:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   byte_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               err_flag;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand;
  logic [31:0]        pick_addr;
  logic [NUM_REQ-1:0] pick_onehot;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (int'(rr_ptr) + k >= NUM_REQ) cand = PTR_W'(int'(rr_ptr) + k - NUM_REQ);
      else                             cand = PTR_W'(int'(rr_ptr) + k);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_addr   = req_addr[{pick_idx, 5'b00000} +: 32];
    pick_onehot = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk96m or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      sd_address <= '0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      err_flag   <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= '0;
    end else begin
      rd_valid <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found && sd_rdy) begin
            grant      <= pick_onehot;
            owner      <= pick_idx;
            sd_address <= pick_addr;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          byte_cnt <= '0;
          tmo_cnt  <= TMO_LOAD;
          err_flag <= 1'b0;
          state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!sd_rdy) begin
            state <= S_XFER;
          end else if (tmo_cnt == '0) begin
            err_flag <= 1'b1;
            state    <= S_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_XFER: begin
          // Overflow bytes are counted (for err) but never forwarded.
          if (sd_data_valid) begin
            if (byte_cnt < CNT_FULL) begin
              rd_data  <= sd_data;
              rd_valid <= grant;
            end
            if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 1'b1;
          end
          if (sd_rdy) state <= S_FINISH;
        end
        S_FINISH: begin
          grant  <= '0;
          rr_ptr <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sd_start = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FINISH) ? grant : '0;
  assign err      = ((state == S_FINISH) && (err_flag || byte_cnt != CNT_FULL)) ? grant : '0;

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Shares one SD-card SPI block-read controller between NUM_REQ sample-voice drivers, for polyphonic playback.
- Sits between the per-voice feed logic and the single SD controller.
- Grants requesters round-robin, issues one block read per grant, and routes returned bytes to the granted voice only.
- Reports per-voice completion and error.

Parameters:
NUM_REQ, 4, number of requesting voices (2..8)
BLOCK_BYTES, 512, bytes expected per block read
START_TIMEOUT, 64, max cycles from sd_start until sd_rdy must drop

Ports:
clk96m  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-voice block read request, level
req_addr  in  32*NUM_REQ  per-voice SD block address; voice i uses bits [32*i+31:32*i]
grant  out  NUM_REQ  one-hot, current owner of the controller
rd_data  out  8  registered byte, broadcast to all voices
rd_valid  out  NUM_REQ  one-hot byte strobe for the owner
done  out  NUM_REQ  one-cycle pulse: owner's transfer finished
err  out  NUM_REQ  one-cycle pulse with done: byte count wrong or start timeout
sd_address  out  32  address to the SD controller
sd_start  out  1  one-cycle start strobe to the SD controller
sd_rdy  in  1  SD controller idle and ready to accept a start
sd_data  in  8  byte from the SD controller
sd_data_valid  in  1  sd_data strobe
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; grant, rd_valid, done, err, sd_start = 0; rd_data = 0; sd_address = 0; busy = 0; rr_ptr = 0; byte count = 0.
- Arbitration, in IDLE only:
  - When any req bit is set and sd_rdy=1, select the first set req at or after index rr_ptr, wrapping modulo NUM_REQ.
  - Register grant (one-hot) and sd_address = that voice's req_addr. Go to ISSUE.
  - If sd_rdy=0, remain in IDLE.
- ISSUE: sd_start=1 for exactly one cycle. Clear the byte count and the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - sd_rdy=0 → go to XFER.
  - Timeout counter reaches START_TIMEOUT → go to FINISH with the error flag set.
- XFER:
  - Each sd_data_valid: capture sd_data into rd_data and set rd_valid[owner]=1 on the next cycle (latency 1). Increment the byte count, saturating at BLOCK_BYTES+1.
  - Bytes beyond BLOCK_BYTES are dropped (no rd_valid) but still count toward the error.
  - sd_rdy returning to 1 → go to FINISH.
  - If sd_data_valid arrives in the same cycle sd_rdy rises, that byte is counted and forwarded.
- FINISH (one cycle):
  - done[owner]=1.
  - err[owner]=1 if the error flag is set or byte count ≠ BLOCK_BYTES.
  - rr_ptr = owner+1 modulo NUM_REQ. grant cleared. Go to IDLE.
- Requester rules:
  - A voice holds req high with req_addr stable until its done pulse.
  - A voice deasserting req mid-transfer does not abort; the block completes and done still pulses.
  - req_addr changes after grant are ignored, because the address is latched.
  - A voice that keeps req high after done is re-arbitrated normally. With other voices requesting, it waits its round-robin turn.
- Minimum gap: a new ISSUE follows FINISH after at least one IDLE cycle.
- sd_data_valid outside XFER is ignored (no rd_valid, no count).
- The count register is wide enough for BLOCK_BYTES+1, i.e. clog2(BLOCK_BYTES+2) bits.
- Reset mid-transfer: all outputs return to reset values immediately; no done or err pulse for the aborted transfer.

Test Plan:
1. req=0001, addr0=0x00000400; model returns 512 bytes 0x00..0xFF repeating → sd_address=0x400, one sd_start pulse, rd_valid[0] 512 pulses each 1 cycle after sd_data_valid, done[0]=1, err=0.
2. req=0110 asserted together, rr_ptr=0 → voice 1 served first, then voice 2. rd_valid never strobes the non-owner; exactly one done per voice.
3. req=1111 held for 8 transfers → grant order 0,1,2,3,0,1,2,3; no voice starved.
4. Model returns 500 bytes, then 514 bytes → done with err=1 for both. The 514 case forwards exactly 512 rd_valid pulses.
5. Model keeps sd_rdy=1 after sd_start → after 64 cycles, done[owner]=1 and err[owner]=1; the next requester is served.
6. Assert rst on byte 200 of a transfer → grant=0, busy=0, no done or err. After release with req still high, the transfer restarts from ISSUE and completes cleanly.
